mdio_master: RTL and testbench

MDIO management-interface master (IEEE 802.3 clause 22) for configuring and polling the Ethernet PHYs attached to the switch. It accepts single register read/write requests over a valid/ready handshake, generates MDC, serialises the 64-bit management frame and returns read data with a presence (turnaround) check. It sits between the switch's management/CSR logic and the PHY pins; tristate pad logic is external.

---
 rtl/mdio_pkg.sv | 26 ++
 rtl/mdio_clock_gen.sv | 40 ++++
 rtl/mdio_master.sv | 152 +++++++++++++++
 tb/tb_mdio_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the clause-22 MDIO master.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA
    } mdio_state_t;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;

    localparam int MDIO_PREAMBLE_BITS = 32;
    localparam int MDIO_FRAME_BITS    = 64;
    localparam int MDIO_HDR_BITS      = 14;

    // Index of the last bit of each frame section
    localparam logic [5:0] MDIO_LAST_PRE = 6'(MDIO_PREAMBLE_BITS - 1);
    localparam logic [5:0] MDIO_LAST_HDR = 6'(MDIO_PREAMBLE_BITS + MDIO_HDR_BITS - 1);
    localparam logic [5:0] MDIO_LAST_TA  = 6'(MDIO_PREAMBLE_BITS + MDIO_HDR_BITS + 1);
    localparam logic [5:0] MDIO_LAST_BIT = 6'(MDIO_FRAME_BITS - 1);

endpackage

// File: rtl/mdio_clock_gen.sv
// MDC divider: registered 50% duty MDC plus first/last-clock-of-bit strobes.
module mdio_clock_gen #(
    parameter int CLOCK_DIV = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic mdc,
    output logic bit_start,
    output logic bit_end
);

    localparam int CW = $clog2(2 * CLOCK_DIV);
    localparam logic [CW-1:0] HALF_LAST   = CW'(CLOCK_DIV - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(2 * CLOCK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            mdc     <= 1'b0;
        end else if (clear || !run) begin
            div_cnt <= '0;
            mdc     <= 1'b0;
        end else if (div_cnt == PERIOD_LAST) begin
            div_cnt <= '0;
            mdc     <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == HALF_LAST)
                mdc <= 1'b1;
        end
    end

    assign bit_start = run && (div_cnt == '0);
    assign bit_end   = run && (div_cnt == PERIOD_LAST);

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one register read/write per request, 64-bit frame on MDC/MDIO.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLOCK_DIV = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_error,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    mdio_state_t state, state_n;
    logic [5:0]  bit_cnt, bit_cnt_n;
    logic        mdio_o_n, mdio_oe_n, resp_valid_n, resp_error_n;
    logic [15:0] resp_rdata_n;
    logic        ta_err, ta_err_n;
    logic        wr_q;
    logic [13:0] hdr_sr;
    logic [15:0] data_sr;
    logic        mdio_sync_p0, mdio_sync_p1;
    logic        bit_start, bit_end, accept;

    assign req_ready = (state == ST_IDLE);
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;

    mdio_clock_gen #(.CLOCK_DIV(CLOCK_DIV)) u_clock_gen (
        .clock     (clock),
        .reset     (reset),
        .run       (busy),
        .clear     (accept),
        .mdc       (mdc),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    // Outputs for bit k+1 are decided on the last clock of bit k
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        mdio_o_n     = mdio_o;
        mdio_oe_n    = mdio_oe;
        resp_valid_n = 1'b0;
        resp_error_n = resp_error;
        resp_rdata_n = resp_rdata;
        ta_err_n     = ta_err;
        if (state == ST_IDLE) begin
            if (req_valid) begin
                state_n   = ST_PRE;
                bit_cnt_n = '0;
                mdio_o_n  = 1'b1;
                mdio_oe_n = 1'b1;
                ta_err_n  = 1'b0;
            end
        end else if (bit_end) begin
            bit_cnt_n = bit_cnt + 6'd1;
            unique case (state)
                ST_PRE: begin
                    if (bit_cnt == MDIO_LAST_PRE) begin
                        state_n  = ST_HDR;
                        mdio_o_n = hdr_sr[13];
                    end
                end
                ST_HDR: begin
                    if (bit_cnt == MDIO_LAST_HDR) begin
                        state_n   = ST_TA;
                        mdio_o_n  = 1'b1;
                        mdio_oe_n = wr_q;
                    end else begin
                        mdio_o_n = hdr_sr[13];
                    end
                end
                ST_TA: begin
                    if (bit_cnt == MDIO_LAST_TA) begin
                        state_n  = ST_DATA;
                        mdio_o_n = wr_q ? data_sr[15] : 1'b1;
                        ta_err_n = !wr_q && mdio_sync_p1;
                    end else begin
                        mdio_o_n = !wr_q;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == MDIO_LAST_BIT) begin
                        state_n      = ST_IDLE;
                        resp_valid_n = 1'b1;
                        mdio_o_n     = 1'b1;
                        mdio_oe_n    = 1'b0;
                        resp_error_n = ta_err;
                        if (!wr_q)
                            resp_rdata_n = {data_sr[14:0], mdio_sync_p1};
                    end else begin
                        mdio_o_n = wr_q ? data_sr[14] : 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            mdio_o     <= 1'b1;
            mdio_oe    <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            ta_err     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            mdio_o     <= mdio_o_n;
            mdio_oe    <= mdio_oe_n;
            resp_valid <= resp_valid_n;
            resp_error <= resp_error_n;
            resp_rdata <= resp_rdata_n;
            ta_err     <= ta_err_n;
        end
    end

    // Synchroniser and shift registers; hdr_sr[13] is always the next header bit to drive
    always_ff @(posedge clock) begin
        mdio_sync_p0 <= mdio_i;
        mdio_sync_p1 <= mdio_sync_p0;
        if (accept) begin
            wr_q    <= req_write;
            hdr_sr  <= {MDIO_ST, req_write ? MDIO_OP_WRITE : MDIO_OP_READ,
                        req_phy_addr, req_reg_addr};
            data_sr <= req_wdata;
        end else begin
            if (state == ST_HDR && bit_start)
                hdr_sr <= {hdr_sr[12:0], 1'b0};
            if (state == ST_DATA && bit_end)
                data_sr <= {data_sr[14:0], mdio_sync_p1};
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: frame-level reference model, PHY responder, directed and random requests.
module tb_mdio_master;

    localparam int D    = 3;
    localparam int BITP = 2 * D;
    localparam int LAT  = 128 * D + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [4:0]  req_phy_addr = '0;
    logic [4:0]  req_reg_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    bit          phy_present = 1'b1;
    logic [15:0] phy_data    = '0;

    bit          m_active = 1'b0;
    bit          m_was_idle = 1'b1;
    bit          m_wr = 1'b0;
    bit          m_present = 1'b0;
    bit          m_rv = 1'b0;
    bit          m_err = 1'b0;
    int          m_t = 0;
    logic [63:0] m_frame = '0;
    logic [15:0] m_rdata = '0;
    logic [15:0] m_phy = '0;

    bit          cap_en = 1'b0;
    logic [63:0] cap = '0;
    bit          cap_oe = 1'b1;

    mdio_master #(.CLOCK_DIV(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_phy_addr (req_phy_addr),
        .req_reg_addr (req_reg_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .busy         (busy),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .mdio_i       (mdio_i)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the pins must show in the cycle following each edge
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_rv     = 1'b0;
            m_err    = 1'b0;
            m_rdata  = '0;
        end else begin
            m_was_idle = !m_active;
            m_rv = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == LAT) begin
                    m_active = 1'b0;
                    m_rv     = 1'b1;
                    if (m_wr) begin
                        m_err = 1'b0;
                    end else begin
                        m_rdata = m_present ? m_phy : 16'hFFFF;
                        m_err   = !m_present;
                    end
                end
            end
            if (m_was_idle && req_valid) begin
                m_active  = 1'b1;
                m_t       = 1;
                m_wr      = req_write;
                m_present = phy_present;
                m_phy     = phy_data;
                m_frame   = {32'hFFFF_FFFF, 2'b01, req_write ? 2'b01 : 2'b10,
                             req_phy_addr, req_reg_addr,
                             req_write ? 2'b10 : 2'b11,
                             req_write ? req_wdata : 16'hFFFF};
            end
        end
    end

    // PHY responder: drives each read bit from the start of its bit period; pull-up otherwise
    always @(negedge clock) begin : phy_model
        int k;
        k = (m_t - 1) / BITP;
        if (m_active && !m_wr && k >= 46 && m_present)
            mdio_i = (k == 46) ? 1'b1 : (k == 47) ? 1'b0 : m_phy[63 - k];
        else
            mdio_i = 1'b1;
    end

    always @(negedge clock) begin : compare
        int  k;
        bit  e_mdc, e_oe, e_o;
        k     = m_active ? (m_t - 1) / BITP : 0;
        e_mdc = m_active && (((m_t - 1) % BITP) >= D);
        e_oe  = m_active && (m_wr || k < 46);
        e_o   = m_active ? m_frame[63 - k] : 1'b1;
        check("ctrl", {req_ready, busy, mdc, mdio_oe, resp_valid, resp_error, resp_rdata},
                      {!m_active, m_active, e_mdc, e_oe, m_rv, m_err, m_rdata});
        if (!m_active || e_oe)
            check("mdio_o", mdio_o, e_o);
        if (cap_en && m_active) begin
            cap_oe &= mdio_oe;
            if (((m_t - 1) % BITP) == D)
                cap[63 - k] = mdio_o;
        end
    end

    task automatic issue(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input bit hold);
        int i;
        @(posedge clock);
        #1;
        req_write    = wr;
        req_phy_addr = pa;
        req_reg_addr = ra;
        req_wdata    = wd;
        req_valid    = 1'b1;
        i = 0;
        do begin
            @(negedge clock);
            i++;
        end while (!req_ready && i < 2000);
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready never rose within %0d cycles", i);
        end
        @(posedge clock);
        #1;
        if (!hold) req_valid = 1'b0;
        req_write    = 1'($urandom);
        req_phy_addr = 5'($urandom);
        req_reg_addr = 5'($urandom);
        req_wdata    = 16'($urandom);
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!resp_valid && n < 2000);
        if (!resp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: no resp_valid within %0d cycles", n);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          n, r1, r2, hi, pulses;
        logic        s [32];
        logic [15:0] d;

        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state",
              {req_ready, busy, mdc, mdio_oe, mdio_o, resp_valid, resp_error, resp_rdata},
              {7'b1000100, 16'h0000});
        @(posedge clock);
        #1 reset = 1'b0;

        // Directed write, captured on MDC rising
        cap = '0;
        cap_oe = 1'b1;
        cap_en = 1'b1;
        issue(1'b1, 5'd1, 5'd0, 16'h1234, 1'b0);
        wait_resp(n);
        cap_en = 1'b0;
        check("wr_latency", n, 385);
        check("wr_stream", cap, 64'hFFFF_FFFF_5082_1234);
        check("wr_oe_all", cap_oe, 1);
        check("wr_error", resp_error, 0);

        // Read with PHY present
        phy_present = 1'b1;
        phy_data    = 16'h796D;
        issue(1'b0, 5'd3, 5'd2, 16'h0000, 1'b0);
        wait_resp(n);
        check("rd_latency", n, 385);
        check("rd_data", resp_rdata, 16'h796D);
        check("rd_error", resp_error, 0);

        // Read with PHY absent
        phy_present = 1'b0;
        issue(1'b0, 5'd7, 5'd1, 16'h0000, 1'b0);
        wait_resp(n);
        check("abs_data", resp_rdata, 16'hFFFF);
        check("abs_error", resp_error, 1);

        // MDC period and duty
        phy_present = 1'b1;
        issue(1'b1, 5'd9, 5'd4, 16'hA5C3, 1'b0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            s[i] = mdc;
        end
        r1 = -1;
        r2 = -1;
        hi = 0;
        for (int i = 1; i < 32; i++)
            if (s[i] && !s[i-1]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        if (r1 >= 0 && r2 > r1)
            for (int i = r1; i < r2; i++) hi += int'(s[i]);
        check("mdc_period", r2 - r1, 6);
        check("mdc_high", hi, 3);
        wait_resp(n);

        // Back-to-back: second request held on req_valid during the first
        phy_present = 1'b1;
        issue(1'b1, 5'd2, 5'd5, 16'hBEEF, 1'b1);
        req_write    = 1'b0;
        req_phy_addr = 5'd4;
        req_reg_addr = 5'd6;
        phy_data     = 16'h0F1E;
        wait_resp(n);
        check("b2b_first_latency", n, 385);
        check("b2b_ready_in_resp", req_ready, 1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        wait_resp(n);
        check("b2b_second_latency", n, 385);
        check("b2b_rdata", resp_rdata, 16'h0F1E);

        // Reset during bit 40 of a read
        phy_data = 16'h1357;
        issue(1'b0, 5'd8, 5'd3, 16'h0000, 1'b0);
        repeat (241) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_outputs",
              {req_ready, busy, mdc, mdio_oe, mdio_o, resp_valid, resp_error, resp_rdata},
              {7'b1000100, 16'h0000});
        @(posedge clock);
        #1 reset = 1'b0;
        pulses = 0;
        repeat (400) begin
            @(negedge clock);
            if (resp_valid) pulses++;
        end
        check("rst_no_resp", pulses, 0);
        d = 16'($urandom);
        phy_data = d;
        issue(1'b0, 5'd8, 5'd3, 16'h0000, 1'b0);
        wait_resp(n);
        check("rst_fresh_latency", n, 385);
        check("rst_fresh_rdata", resp_rdata, d);
        check("rst_fresh_error", resp_error, 0);

        // Random requests, occasional mid-frame reset
        for (int it = 0; it < 30; it++) begin
            bit wr;
            wr = 1'($urandom);
            phy_present = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            phy_data = d;
            repeat ($urandom_range(0, 4)) @(posedge clock);
            issue(wr, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 380)) @(negedge clock);
                #2 reset = 1'b1;
                @(posedge clock);
                #1 reset = 1'b0;
            end else begin
                wait_resp(n);
                check("rand_latency", n, 385);
                if (!wr) begin
                    check("rand_rdata", resp_rdata, phy_present ? d : 16'hFFFF);
                    check("rand_error", resp_error, !phy_present);
                end
            end
        end

        repeat (5) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
